// File: rtl/ssd_bcd_scan_driver.sv
// Four-digit common-anode seven-segment driver: sequential double-dabble
// binary-to-BCD conversion followed by time-multiplexed digit scanning.
module ssd_bcd_scan_driver #(
    parameter int REFRESH_BITS  = 18,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] num,
    output logic        busy,
    output logic [3:0]  Anode,
    output logic [6:0]  LED
);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    state_t                  state_reg, state_next;
    logic [REFRESH_BITS-1:0] cnt_reg;
    logic [12:0]             last_num_reg, last_num_next;
    logic [28:0]             sr_reg, sr_next;      // {bcd[15:0], bin[12:0]}
    logic [3:0]              count_reg, count_next;
    logic [15:0]             disp_reg, disp_next;
    logic [15:0]             bcd_adj;

    // Add-3 correction applied to each BCD nibble before the shift
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (sr_reg[13 + gi*4 +: 4] >= 4'd5)
                                      ? sr_reg[13 + gi*4 +: 4] + 4'd3
                                      : sr_reg[13 + gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        last_num_next = last_num_reg;
        sr_next       = sr_reg;
        count_next    = count_reg;
        disp_next     = disp_reg;
        case (state_reg)
            IDLE: begin
                if (num != last_num_reg) begin
                    sr_next       = {16'd0, num};
                    last_num_next = num;
                    count_next    = 4'd0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                sr_next    = {bcd_adj[14:0], sr_reg[12:0], 1'b0};
                count_next = count_reg + 4'd1;
                if (count_reg == 4'd12) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                disp_next  = sr_reg[28:13];
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            last_num_reg <= 13'd0;
            sr_reg       <= 29'd0;
            count_reg    <= 4'd0;
            disp_reg     <= 16'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_reg + CNT_ONE;
            last_num_reg <= last_num_next;
            sr_reg       <= sr_next;
            count_reg    <= count_next;
            disp_reg     <= disp_next;
        end
    end

    logic [1:0] sel;
    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg;

    assign sel  = cnt_reg[REFRESH_BITS-1 -: 2];
    assign busy = (state_reg != IDLE);

    always_comb begin
        digit = disp_reg[3:0];
        blank = 1'b0;
        case (sel)
            2'd0: digit = disp_reg[3:0];
            2'd1: begin
                digit = disp_reg[7:4];
                blank = BLANK_LEADING && (disp_reg[15:4] == 12'd0);
            end
            2'd2: begin
                digit = disp_reg[11:8];
                blank = BLANK_LEADING && (disp_reg[15:8] == 8'd0);
            end
            default: begin
                digit = disp_reg[15:12];
                blank = BLANK_LEADING && (disp_reg[15:12] == 4'd0);
            end
        endcase
    end

    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

    assign Anode = blank ? 4'b1111 : ~(4'b0001 << sel);
    assign LED   = blank ? 7'b1111111 : seg;

endmodule

// File: doc/ssd_bcd_scan_driver.md
# ssd_bcd_scan_driver

Four-digit seven-segment display controller that sits directly downstream of the RISC FPGA core's 13-bit `ssd_out` value. It converts the binary value (0–8191) to four BCD digits with a sequential double-dabble engine. It then time-multiplexes the digits onto common-anode `Anode`/`LED` board pins, with optional leading-zero blanking. Everything runs on one clock; there is no separate SSD clock domain.

## Interface
- `REFRESH_BITS`, default 18. Width of the free-running refresh counter; digit select is `cnt[REFRESH_BITS-1:REFRESH_BITS-2]`. Must be ≥ 2.
- `BLANK_LEADING`, default 1. 1 blanks leading zero digits; 0 always lights all four digits.
- `clk` input, 1 bit. System clock; all state updates on the rising edge.
- `rst` input, 1 bit. Synchronous, active-high reset.
- `num` input, 13 bits. Unsigned binary value to display.
- `busy` output, 1 bit. High while a conversion is in progress (states SHIFT and LOAD).
- `Anode` output, 4 bits. Active-low digit enables: `[0]` ones, `[1]` tens, `[2]` hundreds, `[3]` thousands.
- `LED` output, 7 bits. Active-low segments, `LED[6:0]` = g,f,e,d,c,b,a.

## Operation
- Registers:
  - refresh counter `cnt`
  - `last_num[12:0]`
  - shift register (13-bit binary + 16-bit BCD)
  - shift count (4 bits)
  - `disp[15:0]` (four BCD digits)
  - FSM state
- FSM states and transitions:
  - IDLE: if `num != last_num`, latch `num` into the binary shift field and `last_num`, clear the BCD field, clear the shift count, go to SHIFT.
  - SHIFT: each cycle, first add 3 to every BCD nibble ≥ 5, then shift {BCD, binary} left by 1 and increment the count. After the 13th shift, go to LOAD.
  - LOAD: copy the BCD field to `disp`, go to IDLE.
- If `num` changes during SHIFT or LOAD, the in-flight conversion still completes with the old latched value. On return to IDLE the mismatch is seen and a new conversion starts. The last value is never lost.
- `cnt` increments every cycle and wraps from all-ones to 0 without a stall.
- Digit select `sel`:
  - 0 → `Anode` = 1110, ones digit
  - 1 → `Anode` = 1101, tens digit
  - 2 → `Anode` = 1011, hundreds digit
  - 3 → `Anode` = 0111, thousands digit
- Blanking (only when `BLANK_LEADING` = 1):
  - Thousands is blank if it is 0.
  - Hundreds is blank if thousands and hundreds are both 0.
  - Tens is blank if thousands, hundreds and tens are all 0.
  - Ones is never blank.
  - A blanked digit drives `Anode` = 1111 and `LED` = 1111111.
- Segment codes (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any nibble > 9 (unreachable) → 1111111.
- `Anode`, `LED` and `busy` are combinational decodes of registered state only. There is no combinational path from `num`.

## Timing
- Reset values, forced on the edge where `rst` = 1:
  - `cnt` = 0, `last_num` = 0, `disp` = 0, state = IDLE.
  - Resulting outputs: `busy` = 0, `Anode` = 1110, `LED` = 1000000 (a lit "0" on the ones digit).
- Reset mid-conversion abandons it: `disp` is cleared to 0 and any pending non-zero `num` restarts conversion on the first non-reset edge.
- Conversion latency:
  - `num` changes and is sampled at edge E0 (IDLE → SHIFT).
  - Shifts occur at edges E1–E13, and `busy` goes high after E0.
  - E14 performs LOAD; `disp` and `LED` reflect the new value after E14, and `busy` goes low after E14.
  - Total: 15 edges from sampling to display update.
- A new value presented while busy is sampled at the first IDLE edge after LOAD, i.e. E15.
- Each digit is active for 2^(REFRESH_BITS-2) cycles. The full scan period is 2^REFRESH_BITS cycles, about 2.6 ms at 100 MHz with the default.

## Test plan
- Reset with `num` = 0 and `REFRESH_BITS` = 4 → `busy` stays 0; `Anode` cycles 1110 →(4 cycles) 1111 → 1111 → 1111 and repeats; `LED` = 1000000 on the ones slot.
- `num` = 8191, `BLANK_LEADING` = 1 → `busy` is high for exactly 14 cycles, then digits ones..thousands show 1, 9, 1, 8 (`LED` 1111001, 0010000, 1111001, 0000000) with all anodes active.
- `num` = 7 → only the ones digit is lit (`Anode` 1110, `LED` 1111000); the other slots give `Anode` 1111. Repeat with `BLANK_LEADING` = 0 → digits show 7, 0, 0, 0.
- `num` = 1005 → digits 5, 0, 0, 1 all lit; internal zeros are not blanked.
- `num` changes 1234 → 4321 three cycles after the first conversion starts → 1234 is displayed after its LOAD, then `busy` re-asserts and 4321 is displayed 15 edges later.
- Assert `rst` for one cycle mid-conversion of 999 with `num` held → display returns to 0 immediately, then shows 9, 9, 9 (blanked thousands) 15 edges after reset is released.
